cpu6_trap_ctrl: RTL and testbench
=================================

Name: cpu6_trap_ctrl

Overview:
Trap and return sequencer for the cpu6 core. It watches the execute stage for illegal-instruction, ecall, mret and external-interrupt events, and picks one event by fixed priority. It then drives the CSR write strobes (mepc, mcause, mstatus), flushes the pipeline for a programmable number of cycles, and issues a single-cycle PC redirect to mtvec or mepc. It sits between the core control unit, the datapath PC mux and the csr block.

Parameters:
XLEN, 32, datapath width (matches CPU6_XLEN)
FLUSH_CYCLES, 2, cycles flush is held after acceptance; legal range 1..15

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high
valid_e  in  1  E stage holds a valid instruction
excp_illinstr_e  in  1  illegal instruction in E
excp_ecall_e  in  1  ecall in E
mret_e  in  1  mret in E
irq_ext  in  1  level external interrupt request
mie  in  1  mstatus.MIE
pc_e  in  XLEN  PC of the E-stage instruction
mtvec  in  XLEN  trap vector from csr
mepc  in  XLEN  current mepc from csr
flush  out  1  kill F/D/E contents
busy  out  1  stall fetch; high whenever not IDLE
redirect_valid  out  1  one-cycle PC redirect strobe
redirect_pc  out  XLEN  redirect target
epc_we  out  1  mepc write strobe
epc_wdata  out  XLEN  mepc write data
cause_we  out  1  mcause write strobe
cause_wdata  out  XLEN  mcause write data
mstatus_trap  out  1  pulse: MPIE<=MIE, MIE<=0
mstatus_mret  out  1  pulse: MIE<=MPIE, MPIE<=1

Behaviour:
- States: IDLE, FLUSH, REDIRECT. Reset puts the FSM in IDLE with the flush counter at 0. All registered outputs reset to 0.
- Accept condition, evaluated only in IDLE: valid_e & (illinstr | ecall | mret | (irq_ext & mie)).
- Priority when several events are present: illinstr > ecall > mret > irq. Exactly one event is accepted per sequence.
- Cycle C (IDLE, accept true):
  - flush is asserted combinationally.
  - The winning event, pc_e, and the target source (mtvec or mepc) are registered.
- Cycle C+1: FSM enters FLUSH; flush=1 and busy=1. Strobes are single-cycle pulses in C+1 only:
  - Trap (illinstr, ecall, irq): epc_we=1, epc_wdata=captured pc_e, cause_we=1, mstatus_trap=1.
  - mret: mstatus_mret=1 only; no epc_we and no cause_we.
- Cause codes:
  - illinstr = 32'h2
  - ecall = 32'hB
  - irq = 32'h8000000B (bit XLEN-1 set)
- Interrupt EPC: mepc receives pc_e; the E instruction is not executed.
- FLUSH duration: held for FLUSH_CYCLES cycles, counted with a down-counter loaded at acceptance. The transition to REDIRECT occurs when the counter reaches 1.
- Cycle C+FLUSH_CYCLES+1: REDIRECT state.
  - redirect_valid=1, flush=0, busy=1.
  - redirect_pc = {mtvec[XLEN-1:2],2'b00} for traps (direct mode only; mode bits are ignored).
  - redirect_pc = mepc for mret. mepc is sampled in REDIRECT, so the value written at C+1 is visible.
- Next cycle returns to IDLE; busy=0.
- Events present while not in IDLE are ignored, not queued. A level irq still pending and enabled in IDLE is accepted afresh.
- mie=0 masks irq_ext entirely. Synchronous exceptions are never masked.
- valid_e=0 suppresses all acceptance (covers bubbles and already-flushed slots).
- Reset asserted in any state: the next cycle is IDLE with all outputs 0 and any CSR strobe withdrawn. No partial redirect is issued.
- redirect_valid and flush are never high in the same cycle.
- Each accepted event produces exactly one redirect_valid pulse.

Decomposition:
- Shared package/defines (cpu6 defines.v): cause-code constants CPU6_CAUSE_ILLINSTR, CPU6_CAUSE_ECALL, CPU6_CAUSE_MEXT_IRQ; FSM state encoding constants; CPU6_XLEN.
- One natural sub-module: cpu6_trap_prio, a combinational priority encoder. It outputs accept, a one-hot event vector, cause_wdata and an is_mret flag.
- Registers use the codebase dff primitives (dffrl-style with synchronous reset).

Test Plan:
- Illegal instruction (valid_e=1, excp_illinstr_e=1, pc_e=0x20, mtvec=0x40) at cycle C:
  - flush=1 at C.
  - At C+1: epc_we=1, epc_wdata=0x20, cause_wdata=0x2, mstatus_trap=1.
  - flush=1 for C+1..C+2.
  - At C+3: redirect_valid=1, redirect_pc=0x40; busy=0 at C+4.
- mret (mepc=0x24) -> mstatus_mret=1 at C+1, epc_we=0 and cause_we=0 throughout, redirect_pc=0x24 at C+3.
- illinstr and irq_ext (mie=1) together -> cause 0x2 only. After return to IDLE, a second sequence with cause 0x8000000B and epc=pc_e of the then-current instruction.
- irq_ext=1 with mie=0 for 20 cycles -> flush, epc_we and redirect_valid stay 0.
- ecall with mtvec=0x43 -> cause 0xB, redirect_pc=0x40. A new ecall pulsed in C+1 or C+2 is ignored: exactly one redirect.
- Reset asserted at C+2 (mid-FLUSH) -> C+3 has all outputs 0, FSM in IDLE, redirect_valid never asserts. A fresh illegal instruction afterwards sequences normally.

Source files
------------

// File: rtl/cpu6_trap_ctrl_pkg.sv
// Shared definitions for the cpu6 trap/return sequencer: datapath width,
// mcause encodings, event indices and FSM state encoding.
package cpu6_trap_ctrl_pkg;

  localparam int CPU6_XLEN = 32;

  // Full mcause values at the native core width.
  localparam logic [CPU6_XLEN-1:0] CPU6_CAUSE_ILLINSTR = 32'h0000_0002;
  localparam logic [CPU6_XLEN-1:0] CPU6_CAUSE_ECALL    = 32'h0000_000B;
  localparam logic [CPU6_XLEN-1:0] CPU6_CAUSE_MEXT_IRQ = 32'h8000_000B;

  // Exception-code field only; the interrupt flag sits in the MSB at any XLEN.
  localparam logic [3:0] CPU6_CODE_ILLINSTR = 4'h2;
  localparam logic [3:0] CPU6_CODE_ECALL    = 4'hB;
  localparam logic [3:0] CPU6_CODE_MEXT_IRQ = 4'hB;

  // Bit positions inside the one-hot event vector.
  localparam int EV_ILLINSTR = 0;
  localparam int EV_ECALL    = 1;
  localparam int EV_MRET     = 2;
  localparam int EV_IRQ      = 3;
  localparam int EV_W        = 4;

  typedef logic [EV_W-1:0] trap_evt_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } trap_state_t;

endpackage

// File: rtl/cpu6_trap_prio.sv
// Fixed-priority event selector for the trap sequencer.
// Order: illegal instruction > ecall > mret > external interrupt.
// The interrupt only participates when enabled by mstatus.MIE, and nothing
// is selected for an invalid E-stage slot.
module cpu6_trap_prio
  import cpu6_trap_ctrl_pkg::*;
#(
  parameter int XLEN = CPU6_XLEN
) (
  input  logic            valid_e,
  input  logic            illinstr,
  input  logic            ecall,
  input  logic            mret,
  input  logic            irq_ext,
  input  logic            mie,
  output logic            accept,
  output trap_evt_t       evt,
  output logic [XLEN-1:0] cause_wdata,
  output logic            is_mret
);

  // Build an mcause word: interrupt flag in the MSB, code in the low nibble.
  function automatic logic [XLEN-1:0] mk_cause(input logic intr, input logic [3:0] code);
    logic [XLEN-1:0] c;
    c          = '0;
    c[XLEN-1]  = intr;
    c[3:0]     = code;
    return c;
  endfunction

  logic irq_en;

  assign irq_en = irq_ext & mie;

  // Pick the single winning event and its cause code.
  always_comb begin
    evt         = '0;
    cause_wdata = '0;
    if (valid_e) begin
      if (illinstr) begin
        evt[EV_ILLINSTR] = 1'b1;
        cause_wdata      = mk_cause(1'b0, CPU6_CODE_ILLINSTR);
      end else if (ecall) begin
        evt[EV_ECALL]    = 1'b1;
        cause_wdata      = mk_cause(1'b0, CPU6_CODE_ECALL);
      end else if (mret) begin
        evt[EV_MRET]     = 1'b1;
      end else if (irq_en) begin
        evt[EV_IRQ]      = 1'b1;
        cause_wdata      = mk_cause(1'b1, CPU6_CODE_MEXT_IRQ);
      end
    end
  end

  assign accept  = |evt;
  assign is_mret = evt[EV_MRET];

endmodule

// File: rtl/cpu6_trap_ctrl.sv
// Trap and return sequencer for the cpu6 core.
// Accepts one event from the E stage while idle, pulses the CSR write
// strobes one cycle later, holds the pipeline flushed for FLUSH_CYCLES
// cycles (legal 1..15) and finally issues a one-cycle PC redirect to
// mtvec (traps, direct mode) or mepc (mret).
module cpu6_trap_ctrl
  import cpu6_trap_ctrl_pkg::*;
#(
  parameter int XLEN         = CPU6_XLEN,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_e,
  input  logic            excp_illinstr_e,
  input  logic            excp_ecall_e,
  input  logic            mret_e,
  input  logic            irq_ext,
  input  logic            mie,
  input  logic [XLEN-1:0] pc_e,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  output logic            flush,
  output logic            busy,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            epc_we,
  output logic [XLEN-1:0] epc_wdata,
  output logic            cause_we,
  output logic [XLEN-1:0] cause_wdata,
  output logic            mstatus_trap,
  output logic            mstatus_mret
);

  localparam int              CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic            accept;
  logic            is_mret;
  trap_evt_t       evt;
  logic [XLEN-1:0] cause;

  trap_state_t     state;
  logic [CNT_W-1:0] cnt;
  trap_evt_t       evt_q;
  logic            flush_q;

  cpu6_trap_prio #(
    .XLEN (XLEN)
  ) u_prio (
    .valid_e     (valid_e),
    .illinstr    (excp_illinstr_e),
    .ecall       (excp_ecall_e),
    .mret        (mret_e),
    .irq_ext     (irq_ext),
    .mie         (mie),
    .accept      (accept),
    .evt         (evt),
    .cause_wdata (cause),
    .is_mret     (is_mret)
  );

  // The accepting cycle must already kill the E-stage instruction, so flush
  // combines the registered FLUSH-state level with the live IDLE acceptance.
  // A reset cycle never starts a new sequence.
  assign flush = flush_q | ((state == ST_IDLE) & accept & ~reset);

  // Redirect target: mepc is read live in REDIRECT so the value written by
  // the csr block one cycle after acceptance is the one used; mtvec mode bits
  // are dropped because only direct mode is supported.
  always_comb begin
    redirect_pc = '0;
    if (redirect_valid) begin
      if (evt_q[EV_MRET]) redirect_pc = mepc;
      else                redirect_pc = mtvec & ~{{(XLEN-2){1'b0}}, 2'b11};
    end
  end

  // Sequencer FSM with registered strobes, flush level, busy and redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      evt_q          <= '0;
      flush_q        <= 1'b0;
      busy           <= 1'b0;
      redirect_valid <= 1'b0;
      epc_we         <= 1'b0;
      epc_wdata      <= '0;
      cause_we       <= 1'b0;
      cause_wdata    <= '0;
      mstatus_trap   <= 1'b0;
      mstatus_mret   <= 1'b0;
    end else begin
      epc_we       <= 1'b0;
      cause_we     <= 1'b0;
      mstatus_trap <= 1'b0;
      mstatus_mret <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state        <= ST_FLUSH;
            cnt          <= CNT_LOAD;
            evt_q        <= evt;
            flush_q      <= 1'b1;
            busy         <= 1'b1;
            epc_we       <= ~is_mret;
            cause_we     <= ~is_mret;
            mstatus_trap <= ~is_mret;
            mstatus_mret <= is_mret;
            epc_wdata    <= pc_e;
            cause_wdata  <= cause;
          end
        end
        ST_FLUSH: begin
          if (cnt == CNT_ONE) begin
            state          <= ST_REDIRECT;
            cnt            <= '0;
            flush_q        <= 1'b0;
            redirect_valid <= 1'b1;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        ST_REDIRECT: begin
          state          <= ST_IDLE;
          redirect_valid <= 1'b0;
          busy           <= 1'b0;
          evt_q          <= '0;
        end
        default: begin
          state          <= ST_IDLE;
          cnt            <= '0;
          flush_q        <= 1'b0;
          busy           <= 1'b0;
          redirect_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu6_trap_ctrl.sv
// Scoreboard bench for cpu6_trap_ctrl: stimulus pushes the expected CSR
// write and redirect transactions; a negedge monitor pops and compares them
// whenever the DUT raises a strobe or a redirect.
`timescale 1ns/1ps
module tb_cpu6_trap_ctrl;

  localparam int XLEN = 32;
  localparam int FC   = 2;

  logic clk = 1'b0;
  logic reset;
  logic valid_e, excp_illinstr_e, excp_ecall_e, mret_e, irq_ext, mie;
  logic [XLEN-1:0] pc_e, mtvec, mepc;
  logic flush, busy, redirect_valid, epc_we, cause_we, mstatus_trap, mstatus_mret;
  logic [XLEN-1:0] redirect_pc, epc_wdata, cause_wdata;

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int rd_count = 0;

  typedef struct {
    int          cyc;
    logic        epc_we;
    logic        cause_we;
    logic        trap;
    logic        mret;
    logic [31:0] epc;
    logic [31:0] cause;
  } csr_t;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
  } rd_t;

  csr_t csr_q[$];
  rd_t  rd_q[$];

  cpu6_trap_ctrl #(
    .XLEN         (XLEN),
    .FLUSH_CYCLES (FC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .valid_e         (valid_e),
    .excp_illinstr_e (excp_illinstr_e),
    .excp_ecall_e    (excp_ecall_e),
    .mret_e          (mret_e),
    .irq_ext         (irq_ext),
    .mie             (mie),
    .pc_e            (pc_e),
    .mtvec           (mtvec),
    .mepc            (mepc),
    .flush           (flush),
    .busy            (busy),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .epc_we          (epc_we),
    .epc_wdata       (epc_wdata),
    .cause_we        (cause_we),
    .cause_wdata     (cause_wdata),
    .mstatus_trap    (mstatus_trap),
    .mstatus_mret    (mstatus_mret)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push_trap(input int c, input logic [31:0] epc, input logic [31:0] cause,
                           input logic [31:0] rpc);
    csr_t e;
    rd_t  r;
    e = '{cyc: c, epc_we: 1'b1, cause_we: 1'b1, trap: 1'b1, mret: 1'b0, epc: epc, cause: cause};
    r = '{cyc: c + FC, pc: rpc};
    csr_q.push_back(e);
    rd_q.push_back(r);
  endtask

  task automatic push_mret(input int c, input logic [31:0] rpc);
    csr_t e;
    rd_t  r;
    e = '{cyc: c, epc_we: 1'b0, cause_we: 1'b0, trap: 1'b0, mret: 1'b1, epc: 32'h0, cause: 32'h0};
    r = '{cyc: c + FC, pc: rpc};
    csr_q.push_back(e);
    rd_q.push_back(r);
  endtask

  // Called just after a posedge: present one E-stage event for a single cycle.
  task automatic fire(input logic ill, input logic ec, input logic mr, input logic [31:0] pc,
                      input logic exp_flush, input string name);
    valid_e         = 1'b1;
    excp_illinstr_e = ill;
    excp_ecall_e    = ec;
    mret_e          = mr;
    pc_e            = pc;
    @(negedge clk);
    cmp({name, "_flush_c"}, {31'b0, flush}, {31'b0, exp_flush});
    @(posedge clk); #1;
    valid_e         = 1'b0;
    excp_illinstr_e = 1'b0;
    excp_ecall_e    = 1'b0;
    mret_e          = 1'b0;
  endtask

  // Called at C+1 (just after posedge): flush/busy profile through C+4.
  task automatic follow(input string name);
    @(negedge clk);
    cmp({name, "_flush_c1"}, {31'b0, flush}, 32'd1);
    cmp({name, "_busy_c1"},  {31'b0, busy},  32'd1);
    @(negedge clk);
    cmp({name, "_flush_c2"}, {31'b0, flush}, 32'd1);
    @(negedge clk);
    cmp({name, "_flush_c3"}, {31'b0, flush}, 32'd0);
    cmp({name, "_busy_c3"},  {31'b0, busy},  32'd1);
    @(negedge clk);
    cmp({name, "_busy_c4"},  {31'b0, busy},  32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_idle(input string name);
    cmp({name, "_ctrl"}, {25'b0, flush, busy, redirect_valid, epc_we, cause_we,
                          mstatus_trap, mstatus_mret}, 32'd0);
    cmp({name, "_rpc"},   redirect_pc, 32'd0);
    cmp({name, "_epcd"},  epc_wdata,   32'd0);
    cmp({name, "_cause"}, cause_wdata, 32'd0);
  endtask

  // Monitor: every cycle check the flush/redirect exclusion and pop expected
  // transactions whenever the DUT presents a CSR strobe or a redirect.
  always @(negedge clk) begin : mon
    csr_t e;
    rd_t  r;
    cmp("flush_redirect_overlap", {31'b0, flush & redirect_valid}, 32'd0);
    if (epc_we | cause_we | mstatus_trap | mstatus_mret) begin
      if (csr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL csr_unexpected: strobes we=%b cw=%b t=%b m=%b with none expected (cycle %0d)",
                 epc_we, cause_we, mstatus_trap, mstatus_mret, cyc);
      end else begin
        e = csr_q.pop_front();
        cmp("csr_cycle",    cyc, e.cyc);
        cmp("csr_epc_we",   {31'b0, epc_we},       {31'b0, e.epc_we});
        cmp("csr_cause_we", {31'b0, cause_we},     {31'b0, e.cause_we});
        cmp("csr_trap",     {31'b0, mstatus_trap}, {31'b0, e.trap});
        cmp("csr_mret",     {31'b0, mstatus_mret}, {31'b0, e.mret});
        if (e.epc_we)   cmp("csr_epc_wdata",   epc_wdata,   e.epc);
        if (e.cause_we) cmp("csr_cause_wdata", cause_wdata, e.cause);
      end
    end
    if (redirect_valid) begin
      rd_count++;
      if (rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL redirect_unexpected: pc 0x%08h with none expected (cycle %0d)",
                 redirect_pc, cyc);
      end else begin
        r = rd_q.pop_front();
        cmp("rd_cycle", cyc, r.cyc);
        cmp("rd_pc",    redirect_pc, r.pc);
        cmp("rd_busy",  {31'b0, busy}, 32'd1);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int   r0;
    logic seen;
    reset           = 1'b1;
    valid_e         = 1'b0;
    excp_illinstr_e = 1'b0;
    excp_ecall_e    = 1'b0;
    mret_e          = 1'b0;
    irq_ext         = 1'b0;
    mie             = 1'b1;
    pc_e            = '0;
    mtvec           = 32'h40;
    mepc            = 32'h24;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Illegal instruction
    push_trap(cyc + 1, 32'h20, 32'h2, 32'h40);
    fire(1'b1, 1'b0, 1'b0, 32'h20, 1'b1, "ill");
    follow("ill");

    // mret returns to mepc without touching mepc/mcause
    mepc = 32'h24;
    push_mret(cyc + 1, 32'h24);
    fire(1'b0, 1'b0, 1'b1, 32'h28, 1'b1, "mret");
    follow("mret");

    // illinstr beats a simultaneous enabled interrupt
    irq_ext = 1'b1;
    mie     = 1'b1;
    push_trap(cyc + 1, 32'h60, 32'h2, 32'h40);
    fire(1'b1, 1'b0, 1'b0, 32'h60, 1'b1, "prio");
    follow("prio");
    repeat (2) @(posedge clk);
    #1;
    // still-pending level interrupt is taken afresh on the next valid slot
    push_trap(cyc + 1, 32'h64, 32'h8000000B, 32'h40);
    fire(1'b0, 1'b0, 1'b0, 32'h64, 1'b1, "irq");
    follow("irq");
    irq_ext = 1'b0;

    // Masked interrupt never starts a sequence
    mie     = 1'b0;
    irq_ext = 1'b1;
    valid_e = 1'b1;
    pc_e    = 32'h70;
    seen    = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | flush | epc_we | redirect_valid | busy;
    end
    cmp("irq_masked", {31'b0, seen}, 32'd0);
    @(posedge clk); #1;
    valid_e = 1'b0;
    irq_ext = 1'b0;
    mie     = 1'b1;

    // ecall with mode bits in mtvec; repeated ecalls during FLUSH ignored
    mtvec = 32'h43;
    r0    = rd_count;
    push_trap(cyc + 1, 32'h30, 32'hB, 32'h40);
    fire(1'b0, 1'b1, 1'b0, 32'h30, 1'b1, "ecall");
    fire(1'b0, 1'b1, 1'b0, 32'h34, 1'b1, "ecall_dup1");
    fire(1'b0, 1'b1, 1'b0, 32'h38, 1'b1, "ecall_dup2");
    repeat (4) @(posedge clk);
    #1;
    cmp("ecall_one_redirect", rd_count - r0, 32'd1);
    mtvec = 32'h40;

    // Reset in the middle of FLUSH cancels the redirect
    r0 = rd_count;
    csr_q.push_back('{cyc: cyc + 1, epc_we: 1'b1, cause_we: 1'b1, trap: 1'b1, mret: 1'b0,
                      epc: 32'h44, cause: 32'h2});
    fire(1'b1, 1'b0, 1'b0, 32'h44, 1'b1, "rst_ill");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_idle("rst_c3");
    repeat (5) @(posedge clk);
    #1;
    cmp("rst_no_redirect", rd_count - r0, 32'd0);

    // Fresh sequence after the abort
    push_trap(cyc + 1, 32'h48, 32'h2, 32'h40);
    fire(1'b1, 1'b0, 1'b0, 32'h48, 1'b1, "post_rst");
    follow("post_rst");

    repeat (3) @(posedge clk);
    #1;
    cmp("csr_q_drained", csr_q.size(), 32'd0);
    cmp("rd_q_drained",  rd_q.size(),  32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
